// File: rtl/execute_divmod_n.sv
// Iterative restoring divider for the execute stage.
// Width and quotient bits retired per cycle are parameters.
module execute_divmod_n #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             unsigned_div,
    input  logic             want_rem,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             ov
);

    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX = ~MIN;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvs;
    logic             sign_q;
    logic             sign_r;
    logic             want_r;

    logic             a_neg;
    logic             b_neg;
    logic             div0;
    logic             ovf;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] spec_q;
    logic [WIDTH-1:0] spec_r;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic [WIDTH-1:0] nq;
    logic [WIDTH:0]   nr;

    always_comb begin
        a_neg  = !unsigned_div && in_a[WIDTH-1];
        b_neg  = !unsigned_div && in_b[WIDTH-1];
        div0   = (in_b == '0);
        ovf    = !unsigned_div && (in_a == MIN) && (in_b == '1);
        mag_a  = a_neg ? -in_a : in_a;
        mag_b  = b_neg ? -in_b : in_b;
        spec_q = MAX;
        spec_r = '0;
        if (div0) begin
            spec_r = in_a;
            if (unsigned_div)
                spec_q = '1;
            else if (in_a[WIDTH-1])
                spec_q = MIN;
        end
    end

    // Chained restoring steps; quo doubles as the dividend shift register.
    always_comb begin
        nq = quo;
        nr = rem;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            nr = {nr[WIDTH-1:0], nq[WIDTH-1]};
            nq = {nq[WIDTH-2:0], 1'b0};
            if (nr >= {1'b0, dvs}) begin
                nr    = nr - {1'b0, dvs};
                nq[0] = 1'b1;
            end
        end
    end

    always_comb begin
        fix_q = sign_q ? -quo : quo;
        fix_r = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            done   <= 1'b0;
            out    <= '0;
            ov     <= 1'b0;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            want_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        want_r <= want_rem;
                        if (div0 || ovf) begin
                            out   <= want_rem ? spec_r : spec_q;
                            ov    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            quo    <= mag_a;
                            dvs    <= mag_b;
                            rem    <= '0;
                            cnt    <= '0;
                            sign_q <= a_neg ^ b_neg;
                            sign_r <= a_neg;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else begin
                        quo <= nq;
                        rem <= nr;
                        if (cnt == LAST)
                            state <= FIX;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else begin
                        out   <= want_r ? fix_r : fix_q;
                        ov    <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
